// File: rtl/rs232_recv_frame.sv
// Parametrised UART receiver: N data bits, optional parity, 1/2 stop bits, valid/ready output.
// Define RS232_RECV_MAJORITY_EN for 3-sample majority voting (decisions land one cycle later).
module rs232_recv_frame #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CycW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);
`ifdef RS232_RECV_MAJORITY_EN
  localparam int unsigned MajDelay = 1;
`else
  localparam int unsigned MajDelay = 0;
`endif
  localparam logic [CycW-1:0] StartAt = CycW'(CLKS_PER_BIT / 2 + MajDelay);
  localparam logic [CycW-1:0] BitLast = CycW'(CLKS_PER_BIT);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e               state;
  logic                 rx_meta, rxs;
  logic [CycW-1:0]      cyc;
  logic [IdxW-1:0]      bit_idx;
  logic                 stop_idx, stop_bad;
  logic                 par_acc, par_bad;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample_bit, sample_now;

`ifdef RS232_RECV_MAJORITY_EN
  logic rx_d1, rx_d2;
  assign sample_bit = (rx_d1 & rx_d2) | (rx_d1 & rxs) | (rx_d2 & rxs);
`else
  assign sample_bit = rxs;
`endif

  // The start bit is sampled half a bit in; every later bit one full bit after the previous.
  assign sample_now = (state == StStart) ? (cyc == StartAt) : (cyc == BitLast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
`ifdef RS232_RECV_MAJORITY_EN
      rx_d1      <= 1'b1;
      rx_d2      <= 1'b1;
`endif
      state      <= StIdle;
      cyc        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      stop_bad   <= 1'b0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
`ifdef RS232_RECV_MAJORITY_EN
      rx_d1     <= rxs;
      rx_d2     <= rx_d1;
`endif
      frame_err <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        StIdle: begin
          // The detect cycle itself counts as cyc 0.
          if (!rxs) begin
            cyc   <= CycW'(1);
            state <= StStart;
          end
        end
        StStart: begin
          if (sample_now) begin
            cyc <= CycW'(1);
            if (sample_bit) begin
              state <= StIdle;
            end else begin
              state   <= StData;
              bit_idx <= '0;
              par_acc <= 1'b0;
              par_bad <= 1'b0;
            end
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        StData: begin
          if (sample_now) begin
            cyc     <= CycW'(1);
            shreg   <= {sample_bit, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ sample_bit;
            if (bit_idx == IdxW'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              stop_bad <= 1'b0;
              state    <= (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_idx <= bit_idx + IdxW'(1);
            end
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        StParity: begin
          if (sample_now) begin
            cyc     <= CycW'(1);
            par_bad <= (PARITY == 1) ? ~(par_acc ^ sample_bit) : (par_acc ^ sample_bit);
            state   <= StStop;
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        StStop: begin
          if (sample_now) begin
            cyc <= CycW'(1);
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              if (stop_bad || !sample_bit) begin
                frame_err <= 1'b1;
                state     <= StBreak;
              end else begin
                state <= StIdle;
                // A word still waiting and not being taken this cycle wins; the new one is lost.
                if (!data_valid || data_ready) begin
                  data_out   <= shreg;
                  parity_err <= par_bad;
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              stop_idx <= 1'b1;
              stop_bad <= !sample_bit;
            end
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        StBreak: begin
          if (rxs) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_recv_frame.sv
// Bench for rs232_recv_frame: frame-level timing predicted arithmetically, output buffer modelled.
module tb_rs232_recv_frame;

  localparam int unsigned Clks  = 10;
  localparam int unsigned DBits = 8;
  localparam int unsigned Par   = 2;
  localparam int unsigned Stops = 2;
`ifdef RS232_RECV_MAJORITY_EN
  localparam int MajD = 1;
`else
  localparam int MajD = 0;
`endif
  localparam int NBits = DBits + ((Par != 0) ? 1 : 0) + Stops;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             rx = 1'b1;
  logic [DBits-1:0] data_out;
  logic             data_valid;
  logic             data_ready = 1'b0;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  rs232_recv_frame #(
    .CLKS_PER_BIT(Clks),
    .DATA_BITS   (DBits),
    .PARITY      (Par),
    .STOP_BITS   (Stops)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected frame outcomes: the cycle of the last stop-bit sample and what it yields.
  int         ev_at [256];
  bit         ev_fe [256];
  logic [7:0] ev_d  [256];
  bit         ev_pe [256];
  int         ev_wr = 0;
  int         ev_rd = 0;

  int         cyc_n = 0;
  logic       m_v = 0, m_pe = 0, m_fe = 0, m_ov = 0;
  logic [7:0] m_d = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!resetn) begin
      m_v <= 0; m_d <= 0; m_pe <= 0; m_fe <= 0; m_ov <= 0;
      ev_rd <= ev_wr;
    end else begin
      m_fe <= 0;
      if (m_v && data_ready) m_v <= 0;
      if (ev_rd < ev_wr && ev_at[ev_rd] == cyc_n) begin
        ev_rd <= ev_rd + 1;
        if (ev_fe[ev_rd]) m_fe <= 1;
        else if (!m_v || data_ready) begin
          m_v <= 1; m_d <= ev_d[ev_rd]; m_pe <= ev_pe[ev_rd];
        end else m_ov <= 1;
      end
    end
  end

  bit         ready_rand = 0;
  int         fe_cnt = 0;
  int         snap_at = -1;
  int         snap_cyc = -2;
  logic       snap_v, snap_pe, snap_fe;
  logic [7:0] snap_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic mon();
    if (resetn) begin
      chk("valid", 32'(data_valid), 32'(m_v));
      chk("data_out", 32'(data_out), 32'(m_d));
      chk("parity_err", 32'(parity_err), 32'(m_pe));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
      chk("overrun", 32'(overrun), 32'(m_ov));
      if (frame_err) fe_cnt++;
      if (cyc_n == snap_at) begin
        snap_cyc = cyc_n;
        snap_v = data_valid; snap_d = data_out; snap_pe = parity_err; snap_fe = frame_err;
      end
    end
  endtask

  // Check at mid-cycle, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (ready_rand) data_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] d, input bit pflip, input bit sbad, input int hold_low);
    logic pbit;
    pbit = ((Par == 1) ? ~^d : ^d) ^ pflip;
    // Pin falls this cycle; rxs follows two cycles later.
    ev_at[ev_wr] = cyc_n + 2 + Clks / 2 + MajD + NBits * Clks;
    ev_fe[ev_wr] = sbad;
    ev_d[ev_wr]  = d;
    ev_pe[ev_wr] = pflip;
    snap_at = ev_at[ev_wr] + 1;
    ev_wr++;
    rx = 1'b0;
    repeat (Clks) tick();
    for (int i = 0; i < int'(DBits); i++) begin
      rx = d[i];
      repeat (Clks) tick();
    end
    if (Par != 0) begin
      rx = pbit;
      repeat (Clks) tick();
    end
    for (int s = 0; s < int'(Stops); s++) begin
      rx = !sbad;
      repeat (Clks) tick();
    end
    repeat (hold_low) tick();
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         pflip;
    bit         sbad;
    bit         exp_v;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int fe0;
    logic [7:0] rd;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(data_valid), 32'd0);
    chk("reset data", 32'(data_out), 32'd0);
    chk("reset perr", 32'(parity_err), 32'd0);
    chk("reset ferr", 32'(frame_err), 32'd0);
    chk("reset ovr", 32'(overrun), 32'd0);
    resetn = 1'b1;
    data_ready = 1'b1;
    repeat (3) tick();

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].pflip, vecs[i].sbad, 0);
      repeat (3) tick();
      chk("vec taken", 32'(snap_cyc), 32'(snap_at));
      chk("vec valid", 32'(snap_v), 32'(vecs[i].exp_v));
      chk("vec data", 32'(snap_d), 32'(vecs[i].exp_d));
      chk("vec perr", 32'(snap_pe), 32'(vecs[i].exp_pe));
      chk("vec ferr", 32'(snap_fe), 32'(vecs[i].exp_fe));
    end

    // Glitch shorter than half a bit.
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (2 * Clks) tick();
    chk("glitch valid", 32'(data_valid), 32'd0);
    chk("glitch ferr", 32'(fe_cnt - fe0), 32'd0);

    // Bad stop bit with the line then held low: one error, no restart.
    fe0 = fe_cnt;
    send(8'h96, 1'b0, 1'b1, 50);
    repeat (2 * Clks) tick();
    chk("break ferr count", 32'(fe_cnt - fe0), 32'd1);
    chk("break valid", 32'(data_valid), 32'd0);

    // Overrun: second word dropped while the first waits.
    data_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0, 0);
    repeat (3) tick();
    send(8'h22, 1'b0, 1'b0, 0);
    repeat (3) tick();
    chk("ovr data", 32'(data_out), 32'h11);
    chk("ovr valid", 32'(data_valid), 32'd1);
    chk("ovr flag", 32'(overrun), 32'd1);
    data_ready = 1'b1;
    tick();
    chk("ovr pop valid", 32'(data_valid), 32'd0);
    data_ready = 1'b0;
    send(8'h33, 1'b0, 1'b0, 0);
    repeat (3) tick();
    chk("held data", 32'(data_out), 32'h33);

    // Reset in the middle of a frame.
    rx = 1'b0;
    repeat (4 * Clks + 3) tick();
    resetn = 1'b0;
    rx = 1'b1;
    #1;
    chk("async valid", 32'(data_valid), 32'd0);
    chk("async data", 32'(data_out), 32'd0);
    chk("async ovr", 32'(overrun), 32'd0);
    chk("async perr", 32'(parity_err), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    data_ready = 1'b1;
    repeat (3) tick();
    send(8'h5A, 1'b0, 1'b0, 0);
    repeat (3) tick();
    chk("post reset taken", 32'(snap_cyc), 32'(snap_at));
    chk("post reset data", 32'(snap_d), 32'h5A);
    chk("post reset valid", 32'(snap_v), 32'd1);

    // Random frames, gaps and consumer back-pressure against the model.
    ready_rand = 1;
    for (int n = 0; n < 40; n++) begin
      bit pf, sb;
      rd = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 7) == 0);
      send(rd, pf, sb, sb ? int'($urandom_range(0, 20)) : 0);
      repeat (sb ? 3 + $urandom_range(0, 5) : $urandom_range(0, 12)) tick();
    end
    ready_rand = 0;
    data_ready = 1'b1;
    repeat (2 * Clks) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
